// File: rtl/exe_operand_stage_if.sv
// ID/EX operand-stage bus. It carries the decoded ID fields, the flush request and the
// MEM/WB forward sources into the stage, and carries the stall and the EX fields back out.
interface exe_operand_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic                  id_rs1_used, id_rs2_used;
  logic [XLEN-1:0]       id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]            id_alu_control;
  logic                  id_alu_src, id_alu_pc;
  logic                  id_reg_write, id_mem_read, id_mem_write;
  logic                  flush;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic [XLEN-1:0]       mem_result;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_reg_write;
  logic [XLEN-1:0]       wb_data;

  logic                  id_stall;
  logic                  exe_valid, exe_reg_write, exe_mem_read, exe_mem_write;
  logic [XLEN-1:0]       exe_pc;
  logic [REG_ADDR_W-1:0] exe_rd;
  logic [3:0]            exe_alu_control;
  logic [XLEN-1:0]       exe_left_operand, exe_right_operand, exe_store_data;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_rs1_data, id_rs2_data, id_imm, id_alu_control, id_alu_src, id_alu_pc,
           id_reg_write, id_mem_read, id_mem_write, flush,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_data,
    input  id_stall, exe_valid, exe_reg_write, exe_mem_read, exe_mem_write,
           exe_pc, exe_rd, exe_alu_control, exe_left_operand, exe_right_operand,
           exe_store_data
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_rs1_data, id_rs2_data, id_imm, id_alu_control, id_alu_src, id_alu_pc,
           id_reg_write, id_mem_read, id_mem_write, flush,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_data,
    output id_stall, exe_valid, exe_reg_write, exe_mem_read, exe_mem_write,
           exe_pc, exe_rd, exe_alu_control, exe_left_operand, exe_right_operand,
           exe_store_data
  );
endinterface

// File: rtl/exe_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use stall detection.
// It drives the execute-stage ALU operands and the control fields carried on to MEM.
module exe_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  exe_operand_stage_if.slave bus
);
  localparam logic [3:0] ALU_ADD = 4'h0;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [3:0]            alu_control;
    logic                  alu_src;
    logic                  alu_pc;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } ex_stage_t;

  ex_stage_t       stage_q, stage_d;
  logic            hazard;
  logic [XLEN-1:0] fwd1, fwd2;

  // x0 is hard-wired zero, so a zero index never matches a forwarding source.
  function automatic logic [XLEN-1:0] forward(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [XLEN-1:0]       held,
    input logic                  mem_we,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic [XLEN-1:0]       mem_val,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]       wb_val
  );
    if (rs == '0)                        return '0;
    else if (mem_we && mem_rd == rs)     return mem_val;
    else if (wb_we && wb_rd == rs)       return wb_val;
    else                                 return held;
  endfunction

  assign hazard = stage_q.valid && stage_q.mem_read && (stage_q.rd != '0) && bus.id_valid &&
                  ((bus.id_rs1_used && bus.id_rs1 == stage_q.rd) ||
                   (bus.id_rs2_used && bus.id_rs2 == stage_q.rd));
  assign bus.id_stall = hazard && !bus.flush;

  always_comb begin
    // NOTE: every field gets its bubble value first so no path leaves stage_d unassigned (no latch).
    stage_d             = '0;
    stage_d.alu_control = ALU_ADD;
    if (!bus.flush && !bus.id_stall && bus.id_valid) begin
      stage_d.valid       = 1'b1;
      stage_d.pc          = bus.id_pc;
      stage_d.rs1         = bus.id_rs1;
      stage_d.rs2         = bus.id_rs2;
      stage_d.rd          = bus.id_rd;
      stage_d.imm         = bus.id_imm;
      stage_d.alu_control = bus.id_alu_control;
      stage_d.alu_src     = bus.id_alu_src;
      stage_d.alu_pc      = bus.id_alu_pc;
      stage_d.reg_write   = bus.id_reg_write;
      stage_d.mem_read    = bus.id_mem_read;
      stage_d.mem_write   = bus.id_mem_write;
      // WB writes the regfile on this same edge, so its value is newer than the read data.
      stage_d.rs1_data = (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == bus.id_rs1)
                         ? bus.wb_data : bus.id_rs1_data;
      stage_d.rs2_data = (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == bus.id_rs2)
                         ? bus.wb_data : bus.id_rs2_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q             <= '0;
      stage_q.alu_control <= ALU_ADD;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      stage_q <= stage_d;
    end
  end

  always_comb begin
    fwd1 = forward(stage_q.rs1, stage_q.rs1_data, bus.mem_reg_write, bus.mem_rd,
                   bus.mem_result, bus.wb_reg_write, bus.wb_rd, bus.wb_data);
    fwd2 = forward(stage_q.rs2, stage_q.rs2_data, bus.mem_reg_write, bus.mem_rd,
                   bus.mem_result, bus.wb_reg_write, bus.wb_rd, bus.wb_data);
  end

  assign bus.exe_valid         = stage_q.valid;
  assign bus.exe_reg_write     = stage_q.reg_write;
  assign bus.exe_mem_read      = stage_q.mem_read;
  assign bus.exe_mem_write     = stage_q.mem_write;
  assign bus.exe_pc            = stage_q.pc;
  assign bus.exe_rd            = stage_q.rd;
  assign bus.exe_alu_control   = stage_q.alu_control;
  assign bus.exe_left_operand  = stage_q.alu_pc ? stage_q.pc : fwd1;
  assign bus.exe_right_operand = stage_q.alu_src ? stage_q.imm : fwd2;
  assign bus.exe_store_data    = fwd2;
endmodule
